// File: rtl/aibcr3_dcc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// aibcr3_dcc_ctrl_fsm
//
// Duty-cycle-correction loop controller. Synchronizes the phase detector
// t_up/t_down outputs, majority-votes them over fixed sample windows and
// steps the DCC code up or down with saturation. After LOCK_TOGGLES
// consecutive direction reversals the loop declares lock and freezes the code.
//
// Ports
//   CLK       in   controller clock
//   RSTb      in   asynchronous reset, active low
//   dcc_en    in   loop enable (level); rising edge restarts the loop
//   t_up      in   phase detector "up", asynchronous to CLK
//   t_down    in   phase detector "down", asynchronous to CLK
//   dcc_code  out  correction code to the delay line
//   dcc_lock  out  loop locked, code frozen
//   dcc_busy  out  loop iterating (not IDLE, not LOCKED)
//   dcc_sat   out  last requested step was clipped at 0 or full scale
//
// Iteration: SETTLE (SETTLE_CYC) -> SAMPLE (2**WIN_LOG2) -> UPDATE (1).
// FF_DELAY is a simulation-only output delay parameter retained for interface
// compatibility; the registers here carry no delay.
// ---------------------------------------------------------------------------
module aibcr3_dcc_ctrl_fsm #(
    parameter int CODE_W       = 5,
    parameter int CODE_INIT    = 16,
    parameter int WIN_LOG2     = 4,
    parameter int SETTLE_CYC   = 8,
    parameter int LOCK_TOGGLES = 4,
    parameter int FF_DELAY     = 20
) (
    input  logic              CLK,
    input  logic              RSTb,
    input  logic              dcc_en,
    input  logic              t_up,
    input  logic              t_down,
    output logic [CODE_W-1:0] dcc_code,
    output logic              dcc_lock,
    output logic              dcc_busy,
    output logic              dcc_sat
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd3;
    localparam logic [2:0] ST_LOCKED = 3'd4;

    localparam int WIN_N = 2 ** WIN_LOG2;
    localparam int CNT_W = WIN_LOG2 + 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TOG_W = $clog2(LOCK_TOGGLES + 1);

    localparam logic [CODE_W-1:0] CODE_MAX   = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_RST   = CODE_W'(CODE_INIT);
    localparam logic [CNT_W-1:0]  HALF_WIN   = CNT_W'(WIN_N / 2);
    localparam logic [SET_W-1:0]  SETTLE_END = SET_W'(SETTLE_CYC - 1);
    localparam logic [TOG_W-1:0]  TOG_LOCK   = TOG_W'(LOCK_TOGGLES);

    // Elaboration-time guard on parameter ranges.
    if (SETTLE_CYC < 3 || FF_DELAY < 0 || CODE_INIT >= 2 ** CODE_W) begin : g_bad_param
        $error("aibcr3_dcc_ctrl_fsm: illegal parameter value");
    end

    logic [2:0]          state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                sat_q, sat_d;
    logic                en_prev_q, en_prev_d;
    logic                up_s1_q, up_s2_q, dn_s1_q, dn_s2_q;
    logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]    up_cnt_q, up_cnt_d;
    logic [CNT_W-1:0]    dn_cnt_q, dn_cnt_d;
    logic [TOG_W-1:0]    toggle_cnt_q, toggle_cnt_d;
    logic                last_vld_q, last_vld_d;
    logic                last_up_q, last_up_d;

    logic                smp_valid;
    logic                step_up, step_dn;
    logic [TOG_W-1:0]    toggle_nx;

    // A sample counts only when the detector gives a clear direction.
    assign smp_valid = up_s2_q ^ dn_s2_q;
    assign step_up   = up_cnt_q > HALF_WIN;
    assign step_dn   = dn_cnt_q > HALF_WIN;

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        sat_d        = sat_q;
        en_prev_d    = dcc_en;
        settle_cnt_d = settle_cnt_q;
        win_cnt_d    = win_cnt_q;
        up_cnt_d     = up_cnt_q;
        dn_cnt_d     = dn_cnt_q;
        toggle_cnt_d = toggle_cnt_q;
        last_vld_d   = last_vld_q;
        last_up_d    = last_up_q;
        toggle_nx    = toggle_cnt_q;

        if (!dcc_en) begin
            // Disable wins from any state; code and sat are held.
            state_d      = ST_IDLE;
            settle_cnt_d = '0;
            win_cnt_d    = '0;
            up_cnt_d     = '0;
            dn_cnt_d     = '0;
            toggle_cnt_d = '0;
            last_vld_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!en_prev_q) begin
                        state_d      = ST_SETTLE;
                        code_d       = CODE_RST;
                        sat_d        = 1'b0;
                        settle_cnt_d = '0;
                        toggle_cnt_d = '0;
                        last_vld_d   = 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_END) begin
                        state_d      = ST_SAMPLE;
                        settle_cnt_d = '0;
                        win_cnt_d    = '0;
                        up_cnt_d     = '0;
                        dn_cnt_d     = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (smp_valid && up_s2_q) up_cnt_d = up_cnt_q + 1'b1;
                    if (smp_valid && dn_s2_q) dn_cnt_d = dn_cnt_q + 1'b1;
                    win_cnt_d = win_cnt_q + 1'b1;
                    if (win_cnt_q == {WIN_LOG2{1'b1}}) state_d = ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (step_up) begin
                        if (code_q == CODE_MAX) sat_d = 1'b1;
                        else begin
                            code_d = code_q + 1'b1;
                            sat_d  = 1'b0;
                        end
                    end else if (step_dn) begin
                        if (code_q == '0) sat_d = 1'b1;
                        else begin
                            code_d = code_q - 1'b1;
                            sat_d  = 1'b0;
                        end
                    end
                    // Reversal tracking; a first decision only seeds last_dir.
                    if (step_up || step_dn) begin
                        if (last_vld_q && (last_up_q != step_up)) toggle_nx = toggle_cnt_q + 1'b1;
                        else if (last_vld_q)                      toggle_nx = '0;
                        last_vld_d = 1'b1;
                        last_up_d  = step_up;
                    end
                    toggle_cnt_d = toggle_nx;
                    settle_cnt_d = '0;
                    state_d      = (toggle_nx == TOG_LOCK) ? ST_LOCKED : ST_SETTLE;
                end
                ST_LOCKED: state_d = ST_LOCKED;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q      <= ST_IDLE;
            code_q       <= CODE_RST;
            sat_q        <= 1'b0;
            en_prev_q    <= 1'b0;
            up_s1_q      <= 1'b0;
            up_s2_q      <= 1'b0;
            dn_s1_q      <= 1'b0;
            dn_s2_q      <= 1'b0;
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
            up_cnt_q     <= '0;
            dn_cnt_q     <= '0;
            toggle_cnt_q <= '0;
            last_vld_q   <= 1'b0;
            last_up_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            sat_q        <= sat_d;
            en_prev_q    <= en_prev_d;
            up_s1_q      <= t_up;
            up_s2_q      <= up_s1_q;
            dn_s1_q      <= t_down;
            dn_s2_q      <= dn_s1_q;
            settle_cnt_q <= settle_cnt_d;
            win_cnt_q    <= win_cnt_d;
            up_cnt_q     <= up_cnt_d;
            dn_cnt_q     <= dn_cnt_d;
            toggle_cnt_q <= toggle_cnt_d;
            last_vld_q   <= last_vld_d;
            last_up_q    <= last_up_d;
        end
    end

    assign dcc_code = code_q;
    assign dcc_sat  = sat_q;
    assign dcc_lock = (state_q == ST_LOCKED);
    assign dcc_busy = (state_q != ST_IDLE) && (state_q != ST_LOCKED);

endmodule
